// File: rtl/fb_pkg.sv
// fb_pkg -- shared definitions for the double frame buffer.
//   FB_H_RES / FB_V_RES / FB_PIX_W / FB_ADDR_W : default geometry and widths
//   fb_state_e                                 : flip/clear control FSM states
package fb_pkg;

    localparam int FB_H_RES  = 320;
    localparam int FB_V_RES  = 240;
    localparam int FB_PIX_W  = 16;
    localparam int FB_ADDR_W = 17;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SWAP_WAIT = 2'd1,
        ST_CLEAR     = 2'd2
    } fb_state_e;

endpackage

// File: rtl/fb_bank.sv
// fb_bank -- simple dual-port RAM, one write port and one registered read
// port. The body is kept in plain inference form so it maps to block RAM.
// Ports:
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write address (must be < DEPTH when we_i is high)
//   wdata_i  : write data
//   raddr_i  : read address, sampled every cycle
//   rdata_o  : read data, one cycle after raddr_i
module fb_bank #(
    parameter int PIX_W  = 16,
    parameter int ADDR_W = 17,
    parameter int DEPTH  = 76800
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [PIX_W-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [PIX_W-1:0]  rdata_o
);

    logic [PIX_W-1:0] mem [DEPTH];

    // No reset on purpose: a resettable output register would block BRAM
    // mapping. The top masks the output during and after reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/double_frame_buffer.sv
// double_frame_buffer -- two-bank frame store with a page flip synchronised
// to vertical blank. The drawing side writes the back bank, the VGA side
// reads the front bank with one cycle of latency.
// Optional feature: define DOUBLE_FRAME_BUFFER_CLEAR_EN to fill the new back
// bank with CLEAR_COLOR after every flip (writes stall during the fill).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   wr_valid / wr_ready : back-bank write handshake
//   wr_addr, wr_pixel   : write address (y*H_RES+x) and data
//   swap_req            : pulse, back frame complete
//   frame_start         : pulse at vertical blank, flip point
//   rd_addr / rd_pixel  : front-bank read, rd_pixel one cycle later
//   front_sel           : bank currently displayed
//   swap_done           : pulse on the cycle front_sel toggles
module double_frame_buffer
    import fb_pkg::*;
#(
    parameter int               PIX_W       = FB_PIX_W,
    parameter int               H_RES       = FB_H_RES,
    parameter int               V_RES       = FB_V_RES,
    parameter int               ADDR_W      = FB_ADDR_W,
    parameter logic [PIX_W-1:0] CLEAR_COLOR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_pixel,
    input  logic              swap_req,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_pixel,
    output logic              front_sel,
    output logic              swap_done
);

    localparam int DEPTH = H_RES * V_RES;

    fb_state_e state_q, state_d;
    logic      front_sel_q, front_sel_d;
    logic      swap_done_q;
    logic      flip;
    logic      rd_vld_q;     // registered "read was in range and not in reset"
    logic      rd_sel_q;     // bank that was front when the read was sampled

    logic              usr_we;
    logic              clr_act;
    logic              bank_we;
    logic [ADDR_W-1:0] bank_waddr;
    logic [PIX_W-1:0]  bank_wdata;
    logic [PIX_W-1:0]  rdata0, rdata1;

`ifdef DOUBLE_FRAME_BUFFER_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
`endif

    // ---------------- control FSM ----------------
    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        flip        = 1'b0;
`ifdef DOUBLE_FRAME_BUFFER_CLEAR_EN
        clr_cnt_d   = clr_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // frame_start alone is ignored here; a flip needs a prior swap_req
                if (swap_req) state_d = ST_SWAP_WAIT;
            end
            ST_SWAP_WAIT: begin
                if (frame_start) begin
                    flip        = 1'b1;
                    front_sel_d = ~front_sel_q;
`ifdef DOUBLE_FRAME_BUFFER_CLEAR_EN
                    state_d     = ST_CLEAR;
                    clr_cnt_d   = '0;
`else
                    state_d     = ST_IDLE;
`endif
                end
            end
`ifdef DOUBLE_FRAME_BUFFER_CLEAR_EN
            ST_CLEAR: begin
                if (clr_cnt_q == LAST_ADDR) state_d = ST_IDLE;
                else                        clr_cnt_d = clr_cnt_q + 1'b1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            front_sel_q <= 1'b0;
            swap_done_q <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
`ifdef DOUBLE_FRAME_BUFFER_CLEAR_EN
            clr_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            swap_done_q <= flip;
            rd_vld_q    <= (32'(rd_addr) < DEPTH);
            // Old front_sel_q is captured, so a read on the flip cycle still
            // returns the pre-flip front bank.
            rd_sel_q    <= front_sel_q;
`ifdef DOUBLE_FRAME_BUFFER_CLEAR_EN
            clr_cnt_q   <= clr_cnt_d;
`endif
        end
    end

    // ---------------- write path ----------------
    assign wr_ready = (state_q == ST_IDLE) && !reset;
    // Out-of-range writes complete the handshake but never reach a bank.
    assign usr_we   = wr_valid && wr_ready && (32'(wr_addr) < DEPTH);

`ifdef DOUBLE_FRAME_BUFFER_CLEAR_EN
    assign clr_act    = (state_q == ST_CLEAR) && !reset;
    assign bank_waddr = clr_act ? clr_cnt_q : wr_addr;
`else
    assign clr_act    = 1'b0;
    assign bank_waddr = wr_addr;
`endif
    assign bank_we    = usr_we || clr_act;
    assign bank_wdata = clr_act ? CLEAR_COLOR : wr_pixel;

    // Back bank is the one not displayed.
    fb_bank #(.PIX_W(PIX_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_bank0 (
        .clk     (clk),
        .we_i    (bank_we && front_sel_q),
        .waddr_i (bank_waddr),
        .wdata_i (bank_wdata),
        .raddr_i (rd_addr),
        .rdata_o (rdata0)
    );

    fb_bank #(.PIX_W(PIX_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_bank1 (
        .clk     (clk),
        .we_i    (bank_we && !front_sel_q),
        .waddr_i (bank_waddr),
        .wdata_i (bank_wdata),
        .raddr_i (rd_addr),
        .rdata_o (rdata1)
    );

    // ---------------- outputs ----------------
    assign rd_pixel  = rd_vld_q ? (rd_sel_q ? rdata1 : rdata0) : '0;
    assign front_sel = front_sel_q;
    assign swap_done = swap_done_q;

endmodule

// File: tb/tb_double_frame_buffer.sv
// tb_double_frame_buffer -- directed self-checking bench for
// double_frame_buffer at default geometry (320x240, 16-bit pixels).
// With DOUBLE_FRAME_BUFFER_CLEAR_EN defined the clear sequence is exercised
// instead of the persistence sequence.
module tb_double_frame_buffer;

    localparam int PIX_W  = 16;
    localparam int ADDR_W = 17;
    localparam int DEPTH  = 76800;
`ifdef DOUBLE_FRAME_BUFFER_CLEAR_EN
    localparam logic [PIX_W-1:0] CLR = 16'h001F;
`else
    localparam logic [PIX_W-1:0] CLR = 16'h0000;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_pixel;
    logic              swap_req;
    logic              frame_start;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_pixel;
    logic              front_sel;
    logic              swap_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    double_frame_buffer #(
        .PIX_W(PIX_W), .H_RES(320), .V_RES(240), .ADDR_W(ADDR_W), .CLEAR_COLOR(CLR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_pixel    (wr_pixel),
        .swap_req    (swap_req),
        .frame_start (frame_start),
        .rd_addr     (rd_addr),
        .rd_pixel    (rd_pixel),
        .front_sel   (front_sel),
        .swap_done   (swap_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [PIX_W-1:0] d);
        wr_valid = 1'b1;
        wr_addr  = ADDR_W'(a);
        wr_pixel = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int a, input logic [PIX_W-1:0] exp);
        rd_addr = ADDR_W'(a);
        tick();
        chk(tag, 32'(rd_pixel), 32'(exp));
    endtask

    initial begin
        int bad;
        int n;
        reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_pixel = '0;
        swap_req = 1'b0; frame_start = 1'b0; rd_addr = '0;
        bad = 0; n = 0;
        repeat (3) tick();
        chk("rst_ready", 32'(wr_ready), 0);
        chk("rst_front", 32'(front_sel), 0);
        chk("rst_done",  32'(swap_done), 0);
        chk("rst_pix",   32'(rd_pixel), 0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", 32'(wr_ready), 1);

`ifdef DOUBLE_FRAME_BUFFER_CLEAR_EN
        // First flip: bank0 becomes back and is cleared.
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        chk("c_flip1_done",  32'(swap_done), 1);
        chk("c_flip1_front", 32'(front_sel), 1);
        while (!wr_ready && n < 100000) begin
            n++;
            tick();
        end
        chk("c_clear_cycles", 32'(n), 32'(DEPTH));
        // Second flip: the cleared bank0 is displayed.
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        chk("c_flip2_front", 32'(front_sel), 0);
        rd_chk("c_rd0",     0,         CLR);
        rd_chk("c_rd5",     5,         CLR);
        rd_chk("c_rd_last", DEPTH - 1, CLR);
        chk("c_mid_clear_ready", 32'(wr_ready), 0);
        // Abort the clear that is still running.
        reset = 1'b1; tick();
        chk("c_rst_front", 32'(front_sel), 0);
        chk("c_rst_pix",   32'(rd_pixel), 0);
        chk("c_rst_ready", 32'(wr_ready), 0);
        reset = 1'b0; #1;
        chk("c_rel_ready", 32'(wr_ready), 1);
        tick();
        chk("c_idle_ready", 32'(wr_ready), 1);
`else
        // frame_start without swap_req does nothing.
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        chk("idle_fs_front", 32'(front_sel), 0);
        chk("idle_fs_done",  32'(swap_done), 0);
        chk("idle_fs_ready", 32'(wr_ready), 1);

        // Fill bank1 (back while front_sel=0).
        wr(5, 16'hABCD);
        wr(7, 16'h0707);
        wr(0, 16'h5555);
        wr(DEPTH - 1, 16'h1234);
        wr(DEPTH, 16'hFFFF);
        // Write accepted together with swap_req still commits.
        wr_valid = 1'b1; wr_addr = ADDR_W'(9); wr_pixel = 16'h0909; swap_req = 1'b1;
        tick();
        wr_valid = 1'b0; swap_req = 1'b0;
        chk("sw_ready", 32'(wr_ready), 0);
        repeat (3) tick();
        chk("sw_front", 32'(front_sel), 0);

        rd_addr = ADDR_W'(5);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        chk("flip_done",  32'(swap_done), 1);
        chk("flip_front", 32'(front_sel), 1);
        chk("flip_ready", 32'(wr_ready), 1);
        tick();
        chk("flip_done_clr", 32'(swap_done), 0);
        chk("flip_rd5", 32'(rd_pixel), 32'hABCD);
        rd_chk("rd0",      0,         16'h5555);
        rd_chk("rd7",      7,         16'h0707);
        rd_chk("rd9_swap", 9,         16'h0909);
        rd_chk("rd_last",  DEPTH - 1, 16'h1234);
        rd_chk("rd_oob",   DEPTH,     16'h0000);

        // Fill bank0, then hold a write during a long SWAP_WAIT.
        wr(5, 16'h0B0B);
        wr(7, 16'h00AA);
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        wr_valid = 1'b1; wr_addr = ADDR_W'(7); wr_pixel = 16'h7777; rd_addr = ADDR_W'(5);
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (wr_ready !== 1'b0) bad++;
            if (front_sel !== 1'b1) bad++;
        end
        chk("stall_viol",  32'(bad), 0);
        chk("stall_ready", 32'(wr_ready), 0);
        chk("stall_rd5",   32'(rd_pixel), 32'hABCD);
        frame_start = 1'b1; tick(); frame_start = 1'b0; wr_valid = 1'b0;
        chk("f2_front",   32'(front_sel), 0);
        chk("preflip_rd", 32'(rd_pixel), 32'hABCD);
        tick();
        chk("postflip_rd", 32'(rd_pixel), 32'h0B0B);
        rd_chk("stall_no_commit", 7, 16'h00AA);

        // swap_req and frame_start together: flip waits for the next frame_start.
        swap_req = 1'b1; frame_start = 1'b1; tick();
        swap_req = 1'b0; frame_start = 1'b0;
        chk("same_front", 32'(front_sel), 0);
        chk("same_done",  32'(swap_done), 0);
        chk("same_ready", 32'(wr_ready), 0);
        repeat (2) tick();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        chk("same_flip_front", 32'(front_sel), 1);
        chk("same_flip_done",  32'(swap_done), 1);
        rd_chk("persist_last", DEPTH - 1, 16'h1234);
        rd_chk("persist_0",    0,         16'h5555);

        // Reset during SWAP_WAIT aborts the flip.
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        reset = 1'b1; tick();
        chk("rst2_front", 32'(front_sel), 0);
        chk("rst2_pix",   32'(rd_pixel), 0);
        chk("rst2_ready", 32'(wr_ready), 0);
        chk("rst2_done",  32'(swap_done), 0);
        reset = 1'b0; #1;
        chk("rst2_rel_ready", 32'(wr_ready), 1);
        rd_chk("rst2_rd5", 5, 16'h0B0B);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
